fp32_cmp_arb: RTL
=================

FP32_CMP_ARB -- requirements
Module: fp32_cmp_arb

Parameters
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one comparator (range 2..8).
REQ-002 Parameter CMP_LAT, default 2, SHALL set the fixed comparator latency in cycles, from op_vld to result_vld.
REQ-003 Parameter MAX_OUT, default 4, SHALL set the maximum number of in-flight operations (range 1..8, at least 1).

Interface
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 req_vld  input  NUM_REQ  SHALL be the per-requester compare request.
REQ-007 req_a, req_b  input  NUM_REQ x fp32_t (32b each)  SHALL be the per-requester operands.
REQ-008 req_rdy  output  NUM_REQ  SHALL be the per-requester grant; a request is accepted when req_vld[i] & req_rdy[i].
REQ-009 rsp_vld  output  NUM_REQ  SHALL be the per-requester one-cycle result strobe.
REQ-010 rsp_result  output  1  SHALL carry the compare result, shared by all requesters and qualified by rsp_vld.
REQ-011 cmp_op_vld  output  1  SHALL drive the comparator op_vld.
REQ-012 cmp_a, cmp_b  output  fp32_t  SHALL drive the comparator operands.
REQ-013 cmp_result_vld, cmp_result  input  1, 1  SHALL be the comparator outputs.
REQ-014 err_orphan  output  1  SHALL be a sticky flag for a comparator result with no matching tag.

Function
REQ-015 Arbitration SHALL be round-robin with pointer rr_ptr, which is 0 after reset.
REQ-016 The grant SHALL go to the first i with req_vld[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
REQ-017 req_rdy SHALL be combinational and one-hot or zero, and SHALL be asserted only to the granted requester.
REQ-018 After an accepted grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-019 No grant SHALL be issued while out_cnt == MAX_OUT, where out_cnt counts issued operations whose result has not yet been consumed.
REQ-020 The requester SHALL hold req_vld and its operands stable until accepted; the block SHALL NOT check this.
REQ-021 The issue stage SHALL be registered: an acceptance at edge T SHALL drive cmp_op_vld=1 with the latched operands for exactly the cycle after T.
REQ-022 cmp_op_vld SHALL be 0 in all other cycles, and cmp_a/cmp_b SHALL hold their last value.
REQ-023 At the acceptance edge, the granted index SHALL be pushed into an in-order tag FIFO of depth MAX_OUT.
REQ-024 On cmp_result_vld=1 with the FIFO non-empty, the FIFO SHALL pop tag t.
REQ-025 In the cycle after that pop, rsp_vld[t] SHALL be 1 and rsp_result SHALL equal the captured cmp_result; all other rsp_vld bits SHALL be 0.
REQ-026 The end-to-end latency from acceptance edge to rsp_vld SHALL be exactly CMP_LAT+2 cycles.
REQ-027 Responses SHALL have no backpressure.
REQ-028 A simultaneous push and pop SHALL leave out_cnt unchanged.
REQ-029 A pop and a grant in the same cycle while out_cnt == MAX_OUT SHALL NOT be allowed; the grant SHALL wait one cycle.
REQ-030 out_cnt SHALL never exceed MAX_OUT or underflow.
REQ-031 The FIFO read and write pointers SHALL wrap modulo MAX_OUT.
REQ-032 cmp_result_vld=1 with the FIFO empty SHALL be dropped, and err_orphan SHALL be set unless the drain window is active (REQ-037).
REQ-033 Once set, err_orphan SHALL clear only on rst.

Reset
REQ-034 While rst=1, all of the following SHALL be 0 the cycle after: req_rdy, cmp_op_vld, rsp_vld, rsp_result, cmp_a, cmp_b, err_orphan, out_cnt, the FIFO pointers and rr_ptr.
REQ-035 req_rdy SHALL be forced to 0 while rst=1.
REQ-036 A reset mid-operation SHALL discard all in-flight tags; no rsp_vld SHALL be generated for operations issued before reset.
REQ-037 Because the comparator is not reset, a drain counter SHALL run for CMP_LAT+1 cycles after rst deasserts; during that window, orphan results SHALL be dropped silently without setting err_orphan.
REQ-038 Grants SHALL remain enabled during the drain window.
REQ-039 A result from a post-reset issue cannot arrive before CMP_LAT+1 cycles, so it SHALL NOT fall in the drain window.

Verification
REQ-040 Single request: req_vld[2]=1, a=1.0, b=2.0, with a model comparator of LT type, CMP_LAT=2, accepted at edge T -> cmp_op_vld at T+1; rsp_vld[2]=1 and rsp_result=1 at T+4 only.
REQ-041 All four requesters held valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; each response is routed to its own requester in issue order.
REQ-042 MAX_OUT=2 with CMP_LAT=4 and continuous requests -> at most 2 in flight; req_rdy stays low while out_cnt=2 and resumes the cycle after a pop.
REQ-043 Reset asserted one cycle after 3 issues -> no rsp_vld afterward, err_orphan stays 0 through the drain, and a new request after reset returns correctly.
REQ-044 Inject cmp_result_vld=1 with an empty FIFO, 10 cycles after reset -> err_orphan=1 and stays 1 until the next rst.
REQ-045 Requester 3 only, then requester 0 plus 3 together -> the grant goes to 0 (rr_ptr wrapped to 0), then 3.

Source files
------------

// File: rtl/fp32_cmp_arb.sv
// Round-robin arbiter sharing one external fp32 comparator among NUM_REQ requesters.
// Results are routed back through an in-order tag FIFO; a post-reset drain window absorbs stale results.
module fp32_cmp_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CMP_LAT = 2,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic [NUM_REQ-1:0]   rsp_vld,
    output logic                 rsp_result,
    output logic                 cmp_op_vld,
    output logic [31:0]          cmp_a,
    output logic [31:0]          cmp_b,
    input  logic                 cmp_result_vld,
    input  logic                 cmp_result,
    output logic                 err_orphan
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned DRN_W = $clog2(CMP_LAT + 2);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]   tag_q [MAX_OUT];
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               cmp_op_vld_q;
    logic [31:0]        cmp_a_q, cmp_b_q;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic               rsp_result_q, rsp_result_d;
    logic               err_orphan_q, err_orphan_d;

    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [31:0]        sel_a, sel_b;
    logic               full, accept, pop, orphan;

    // First valid requester at or after rr_ptr, plus its operands
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_any && req_vld[IDX_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign full    = (out_cnt_q == CNT_W'(MAX_OUT));
    assign accept  = grant_any && !full && !rst;
    assign req_rdy = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    // Any result inside the drain window belongs to an operation issued before reset
    assign pop    = cmp_result_vld && (out_cnt_q != '0) && (drain_q == '0);
    assign orphan = cmp_result_vld && (out_cnt_q == '0) && (drain_q == '0);

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_cnt_d    = out_cnt_q;
        rsp_vld_d    = '0;
        rsp_result_d = rsp_result_q;
        err_orphan_d = err_orphan_q | orphan;
        drain_d      = (drain_q != '0) ? drain_q - 1'b1 : drain_q;

        if (accept) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d     = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
            rsp_vld_d    = NUM_REQ'(1) << tag_q[rd_ptr_q];
            rsp_result_d = cmp_result;
        end
        if (accept && !pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!accept && pop) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            out_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drain_q      <= DRN_W'(CMP_LAT + 1);
            cmp_op_vld_q <= 1'b0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            rsp_vld_q    <= '0;
            rsp_result_q <= 1'b0;
            err_orphan_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_cnt_q    <= out_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drain_q      <= drain_d;
            cmp_op_vld_q <= accept;
            rsp_vld_q    <= rsp_vld_d;
            rsp_result_q <= rsp_result_d;
            err_orphan_q <= err_orphan_d;
            if (accept) begin
                cmp_a_q         <= sel_a;
                cmp_b_q         <= sel_b;
                tag_q[wr_ptr_q] <= grant_idx;
            end
        end
    end

    assign cmp_op_vld = cmp_op_vld_q;
    assign cmp_a      = cmp_a_q;
    assign cmp_b      = cmp_b_q;
    assign rsp_vld    = rsp_vld_q;
    assign rsp_result = rsp_result_q;
    assign err_orphan = err_orphan_q;

endmodule
